// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master/slave state encodings, R/W values and the default address.
package i2c_pkg;

    localparam logic [2:0] MASTER_STATE_IDLE  = 3'd0;
    localparam logic [2:0] MASTER_STATE_START = 3'd1;
    localparam logic [2:0] MASTER_STATE_ADDR  = 3'd2;
    localparam logic [2:0] MASTER_STATE_DATA  = 3'd3;
    localparam logic [2:0] MASTER_STATE_ACK   = 3'd4;
    localparam logic [2:0] MASTER_STATE_STOP  = 3'd5;

    localparam logic [2:0] SLAVE_STATE_IDLE       = 3'd0;
    localparam logic [2:0] SLAVE_STATE_ADDRESSING = 3'd1;
    localparam logic [2:0] SLAVE_STATE_ADDR_ACK   = 3'd2;
    localparam logic [2:0] SLAVE_STATE_RX         = 3'd3;
    localparam logic [2:0] SLAVE_STATE_RX_ACK     = 3'd4;
    localparam logic [2:0] SLAVE_STATE_TX         = 3'd5;
    localparam logic [2:0] SLAVE_STATE_TX_ACK     = 3'd6;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

    typedef enum logic [2:0] {
        S_IDLE       = SLAVE_STATE_IDLE,
        S_ADDRESSING = SLAVE_STATE_ADDRESSING,
        S_ADDR_ACK   = SLAVE_STATE_ADDR_ACK,
        S_RX         = SLAVE_STATE_RX,
        S_RX_ACK     = SLAVE_STATE_RX_ACK,
        S_TX         = SLAVE_STATE_TX,
        S_TX_ACK     = SLAVE_STATE_TX_ACK
    } slave_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Input synchronizer with one history flop; yields the synced level and rise/fall strobes.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] chain;
    logic              hist;

    // Reset to 1 so an idle bus produces no spurious edges after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '1;
            hist  <= 1'b1;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            hist  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~hist;
    assign fall = ~sync & hist;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: oversampled START/STOP detection, address match, byte receive and transmit.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic [7:0] data_in,
    output logic       tx_load,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       rw,
    output logic [2:0] state
);
    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst(rst), .din(sclk),
        .sync(scl_s), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst(rst), .din(sda_in),
        .sync(sda_s), .rise(sda_rise), .fall(sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    slave_state_e state_q, state_d;
    // Only 7 bits are stored: the 8th received bit and the first transmitted bit bypass it.
    logic [6:0]   shift_q, shift_d;
    logic [2:0]   cnt_q, cnt_d;
    // ACK states: 0 = waiting for the fall that drives, 1 = waiting to exit.
    // TX: 1 = reload data_in on the next fall.
    logic         phase_q, phase_d;
    logic         sda_out_d, rw_d, data_valid_d, tx_load_d;
    logic [7:0]   data_out_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            sda_out    <= 1'b1;
            rw         <= WRITE;
            data_out   <= '0;
            data_valid <= 1'b0;
            tx_load    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            sda_out    <= sda_out_d;
            rw         <= rw_d;
            data_out   <= data_out_d;
            data_valid <= data_valid_d;
            tx_load    <= tx_load_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        sda_out_d    = sda_out;
        rw_d         = rw;
        data_out_d   = data_out;
        data_valid_d = 1'b0;
        tx_load_d    = 1'b0;

        if (stop_det || start_det) begin
            state_d   = stop_det ? S_IDLE : S_ADDRESSING;
            shift_d   = '0;
            cnt_d     = '0;
            phase_d   = 1'b0;
            sda_out_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: ;

                S_ADDRESSING: if (scl_rise) begin
                    shift_d = {shift_q[5:0], sda_s};
                    if (cnt_q == 3'd7) begin
                        cnt_d = '0;
                        // shift_q holds the 7 address bits; this rise carries R/W.
                        if (shift_q == SLAVE_ADDR) begin
                            rw_d    = sda_s;
                            phase_d = 1'b0;
                            state_d = S_ADDR_ACK;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end

                S_ADDR_ACK, S_RX_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_out_d = 1'b0;
                        phase_d   = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        cnt_d   = '0;
                        if (state_q == S_ADDR_ACK && rw == READ) begin
                            state_d   = S_TX;
                            shift_d   = data_in[6:0];
                            sda_out_d = data_in[7];
                            tx_load_d = 1'b1;
                        end else begin
                            state_d   = S_RX;
                            sda_out_d = 1'b1;
                        end
                    end
                end

                S_RX: if (scl_rise) begin
                    shift_d = {shift_q[5:0], sda_s};
                    if (cnt_q == 3'd7) begin
                        cnt_d        = '0;
                        data_out_d   = {shift_q, sda_s};
                        data_valid_d = 1'b1;
                        phase_d      = 1'b0;
                        state_d      = S_RX_ACK;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end

                S_TX: begin
                    if (scl_fall) begin
                        if (phase_q) begin
                            phase_d   = 1'b0;
                            shift_d   = data_in[6:0];
                            sda_out_d = data_in[7];
                            tx_load_d = 1'b1;
                        end else begin
                            sda_out_d = shift_q[6];
                            shift_d   = {shift_q[5:0], 1'b1};
                        end
                    end else if (scl_rise && !phase_q) begin
                        if (cnt_q == 3'd7) begin
                            cnt_d   = '0;
                            phase_d = 1'b0;
                            state_d = S_TX_ACK;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end

                S_TX_ACK: begin
                    if (scl_fall && !phase_q) begin
                        sda_out_d = 1'b1;
                        phase_d   = 1'b1;
                    end else if (scl_rise && phase_q) begin
                        // Master ACK -> next byte loads on the coming fall; NACK -> done.
                        if (!sda_s) begin
                            state_d = S_TX;
                            phase_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            phase_d = 1'b0;
                        end
                    end
                end

                default: begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    phase_d   = 1'b0;
                    sda_out_d = 1'b1;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule
